hourglass_matrix_gen: RTL and testbench
=======================================

Name: hourglass_matrix_gen

Overview:
- Parametrised N x N dual-colour hourglass matrix engine. Holds the sand state of two triangular quadrant pairs (left, right), drains or refills them one grain per tick, and drives the row-scanned LED matrix.
- Successor to the fixed 8x8 two-clock driver. Changes: single clock with a tick strobe, internal side alternation with skip-when-blocked, grain counters, done flag, and a configurable row dwell with blanking.

Parameters:
- N, 8, matrix size; even, >=4. H=N/2, K=H*(H+1)/2 grains per side, CW=clog2(K+1) (derived localparams).
- SCAN_DIV, 1, clk cycles per scanned row; >=1.
- BLANK, 0, blank cycles at the start of each row slot; must be < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-clk grain-step strobe
- sw1  in  1  gravity: 1 = drain upper (left shifts left, right shifts right); 0 = refill
- stop  in  1  1 = freeze sand state; ticks ignored
- r_col  out  N  red column drive, active-high
- g_col  out  N  green column drive, active-high
- row  out  N  row select, active-low one-hot
- cnt_l  out  CW  grains in upper-left quadrant
- cnt_r  out  CW  grains in upper-right quadrant
- done  out  1  flow finished in the current gravity direction

Behaviour:
- Reset (rst=0, async): sand_l, sand_r = all ones; side=0 (left); cnt_l = cnt_r = K; scan row=0, div=0; outputs row=all ones, r_col=g_col=0, done=0.
- State: sand_l[K-1:0], sand_r[K-1:0]. Bit=1 means a grain is in the upper quadrant. Neck bit: sand_l[K-1], sand_r[0].
- Left drain: shift left, 0 in at bit0. Left fill: shift right, 1 in at bit K-1.
- Right drain: shift right, 0 in at bit K-1. Right fill: shift left, 1 in at bit0.
- Movable: drain requires the side's count > 0; fill requires count < K.
- Tick step (rising clk with tick=1, stop=0):
  - If side `side` is movable, move it.
  - Else, if the other side is movable, move the other side.
  - Else, no move.
  - After any move, side := opposite of the side moved. With no move, side is unchanged.
  - Counts update on the same edge (±1).
- stop=1: ticks ignored; scanning continues.
- sw1 is sampled per tick; a change takes effect on the next tick.
- done (registered, next edge after a state change): sw1=1 and cnt_l=cnt_r=0, or sw1=0 and cnt_l=cnt_r=K.
  - Consequence: done=1 from reset if sw1=0.
  - A tick while done has no effect.
- Scan:
  - div counts 0..SCAN_DIV-1. On wrap, row index r increments mod N.
  - Outputs are registered every cycle from the current r, div and sand state, so a sand change is visible one cycle later.
- Blanking: while div < BLANK, row=all ones and r_col=g_col=0.
- Active row r < H, triangle row i=r, B(i)=sum_{j<i}(H-j):
  - For m=0..H-1-i: r_col[H+m]=sand_l[B(i)+m]; r_col[H-1-m]=sand_r[K-1-B(i)-m].
  - g_col = inverse of those same bits at the same positions.
  - All other column bits = 0. row[r]=0, all other row bits = 1.
- Active row r >= H: mirrored with i=N-1-r. Same positions, r_col takes the inverted bits and g_col the true bits.
- Asynchronous reset mid-scan or mid-step: everything returns to the reset values immediately. The first output after release is row 0, slot start.

Test Plan:
- Reset, N=8, sw1=1: during rst=0 → row=FF, r_col=g_col=00, cnt_l=cnt_r=10, done=0. After release with SCAN_DIV=1 → row=FE, r_col=FF, g_col=00, and row cycles FE,FD,...,7F every 8 clk.
- sw1=1, 3 ticks → sand_l=10'h3FC, sand_r=10'h1FF, cnt_l=8, cnt_r=9, side=1. Row 0 → r_col=C7, g_col=38. Row 3 → r_col=18, g_col=00. Row 7 → r_col=38, g_col=C7.
- Continue to 20 total ticks → cnt_l=cnt_r=0, done=1, r_col=00 on rows 0-3. 21st tick → no change.
- From the 3-tick state, set sw1=0 and apply 3 ticks:
  - Tick 1 fills right → cnt_r=10.
  - Tick 2 fills left → cnt_l=9.
  - Tick 3: right is full, so it skips to left → cnt_l=10, done=1.
- stop=1 held across 5 ticks → counts, sand state and side unchanged. Scan continues. Ticks after stop=0 resume alternation.
- N=8, SCAN_DIV=4, BLANK=1 → each row shows 1 blank cycle (row=FF, cols 00) then 3 active cycles; frame period 32 clk. Asserting rst low mid-frame → outputs blank immediately, counts=10.

Source files
------------

// File: rtl/hourglass_matrix_gen.sv
// Dual-colour N x N hourglass engine: two triangular sand quadrant pairs that
// drain or refill one grain per tick, rendered onto a row-scanned LED matrix.
module hourglass_matrix_gen #(
    parameter  int N        = 8,
    parameter  int SCAN_DIV = 1,
    parameter  int BLANK    = 0,
    localparam int H        = N / 2,
    localparam int K        = H * (H + 1) / 2,
    localparam int CW       = $clog2(K + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          sw1,
    input  logic          stop,
    output logic [N-1:0]  r_col,
    output logic [N-1:0]  g_col,
    output logic [N-1:0]  row,
    output logic [CW-1:0] cnt_l,
    output logic [CW-1:0] cnt_r,
    output logic          done
);

    typedef enum logic {SIDE_L = 1'b0, SIDE_R = 1'b1} side_e;

    localparam int RW = $clog2(N);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] K_V      = CW'(K);
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [K-1:0]  sand_l_q, sand_l_d;
    logic [K-1:0]  sand_r_q, sand_r_d;
    logic [CW-1:0] cnt_l_q, cnt_l_d;
    logic [CW-1:0] cnt_r_q, cnt_r_d;
    side_e         side_q, side_d;
    logic [RW-1:0] row_idx_q, row_idx_d;
    logic [DW-1:0] div_q, div_d;
    logic [N-1:0]  row_q, row_d;
    logic [N-1:0]  r_col_q, r_col_d;
    logic [N-1:0]  g_col_q, g_col_d;
    logic          done_q, done_d;

    logic movable_l, movable_r, step, move_l, move_r;
    logic blank, upper;
    logic [RW-1:0] tri_i;
    logic [N-1:0]  pat [H];
    logic [N-1:0]  msk [H];
    logic [N-1:0]  pat_sel, msk_sel;

    // First bit of triangle row i inside a side's K-bit sand vector.
    function automatic int tri_base(input int i);
        return i * H - (i * (i - 1)) / 2;
    endfunction

    // ------------------------------------------------------------ sand step
    assign movable_l = sw1 ? (cnt_l_q != '0) : (cnt_l_q != K_V);
    assign movable_r = sw1 ? (cnt_r_q != '0) : (cnt_r_q != K_V);
    assign step      = tick && !stop;
    // Preferred side first; fall back to the other side only when blocked.
    assign move_l    = step && movable_l && (side_q == SIDE_L || !movable_r);
    assign move_r    = step && movable_r && (side_q == SIDE_R || !movable_l);

    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves a signal unassigned would infer a latch.
    always_comb begin
        sand_l_d = sand_l_q;
        sand_r_d = sand_r_q;
        cnt_l_d  = cnt_l_q;
        cnt_r_d  = cnt_r_q;
        side_d   = side_q;
        if (move_l) begin
            if (sw1) begin
                sand_l_d = {sand_l_q[K-2:0], 1'b0};
                cnt_l_d  = cnt_l_q - CW'(1);
            end else begin
                sand_l_d = {1'b1, sand_l_q[K-1:1]};
                cnt_l_d  = cnt_l_q + CW'(1);
            end
            side_d = SIDE_R;
        end
        if (move_r) begin
            if (sw1) begin
                sand_r_d = {1'b0, sand_r_q[K-1:1]};
                cnt_r_d  = cnt_r_q - CW'(1);
            end else begin
                sand_r_d = {sand_r_q[K-2:0], 1'b1};
                cnt_r_d  = cnt_r_q + CW'(1);
            end
            side_d = SIDE_L;
        end
    end

    assign done_d = ( sw1 && cnt_l_q == '0  && cnt_r_q == '0) ||
                    (!sw1 && cnt_l_q == K_V && cnt_r_q == K_V);

    // ----------------------------------------------------------------- scan
    always_comb begin
        div_d     = div_q + DW'(1);
        row_idx_d = row_idx_q;
        if (div_q == DIV_LAST) begin
            div_d     = '0;
            row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + RW'(1);
        end
    end

    if (BLANK > 0) begin : g_blank
        assign blank = (div_q < DW'(BLANK));
    end else begin : g_no_blank
        assign blank = 1'b0;
    end

    // Per triangle row: true sand bits and the columns that row occupies.
    always_comb begin
        for (int i = 0; i < H; i++) begin
            pat[i] = '0;
            msk[i] = '0;
            for (int m = 0; m < H - i; m++) begin
                pat[i][H+m]   = sand_l_q[tri_base(i) + m];
                pat[i][H-1-m] = sand_r_q[K - 1 - tri_base(i) - m];
                msk[i][H+m]   = 1'b1;
                msk[i][H-1-m] = 1'b1;
            end
        end
    end

    assign upper = (row_idx_q < RW'(H));
    assign tri_i = upper ? row_idx_q : ROW_LAST - row_idx_q;

    always_comb begin
        pat_sel = '0;
        msk_sel = '0;
        for (int i = 0; i < H; i++) begin
            if (tri_i == RW'(i)) begin
                pat_sel = pat[i];
                msk_sel = msk[i];
            end
        end
    end

    // Lower half mirrors the upper half with the colours swapped.
    always_comb begin
        row_d   = '1;
        r_col_d = '0;
        g_col_d = '0;
        if (!blank) begin
            row_d = ~(N'(1) << row_idx_q);
            if (upper) begin
                r_col_d = pat_sel;
                g_col_d = ~pat_sel & msk_sel;
            end else begin
                r_col_d = ~pat_sel & msk_sel;
                g_col_d = pat_sel;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sand_l_q  <= '1;
            sand_r_q  <= '1;
            cnt_l_q   <= K_V;
            cnt_r_q   <= K_V;
            side_q    <= SIDE_L;
            row_idx_q <= '0;
            div_q     <= '0;
            row_q     <= '1;
            r_col_q   <= '0;
            g_col_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            sand_l_q  <= sand_l_d;
            sand_r_q  <= sand_r_d;
            cnt_l_q   <= cnt_l_d;
            cnt_r_q   <= cnt_r_d;
            side_q    <= side_d;
            row_idx_q <= row_idx_d;
            div_q     <= div_d;
            row_q     <= row_d;
            r_col_q   <= r_col_d;
            g_col_q   <= g_col_d;
            done_q    <= done_d;
        end
    end

    assign r_col = r_col_q;
    assign g_col = g_col_q;
    assign row   = row_q;
    assign cnt_l = cnt_l_q;
    assign cnt_r = cnt_r_q;
    assign done  = done_q;

endmodule

// File: tb/tb_hourglass_matrix_gen.sv
// Directed bench for hourglass_matrix_gen: an unblanked 8x8 instance and a
// SCAN_DIV=4/BLANK=1 instance share clock and control inputs.
module tb_hourglass_matrix_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic sw1 = 1'b1;
    logic stop = 1'b0;

    logic [7:0] r_col_a, g_col_a, row_a;
    logic [3:0] cnt_l_a, cnt_r_a;
    logic       done_a;
    logic [7:0] r_col_b, g_col_b, row_b;
    logic [3:0] cnt_l_b, cnt_r_b;
    logic       done_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hourglass_matrix_gen #(.N(8), .SCAN_DIV(1), .BLANK(0)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .sw1(sw1), .stop(stop),
        .r_col(r_col_a), .g_col(g_col_a), .row(row_a),
        .cnt_l(cnt_l_a), .cnt_r(cnt_r_a), .done(done_a)
    );

    hourglass_matrix_gen #(.N(8), .SCAN_DIV(4), .BLANK(1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .sw1(sw1), .stop(stop),
        .r_col(r_col_b), .g_col(g_col_b), .row(row_b),
        .cnt_l(cnt_l_b), .cnt_r(cnt_r_b), .done(done_b)
    );

    task automatic do_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    // Bounded wait (negedge sampled) until dut_a selects the given row.
    task automatic wait_row_a(input logic [7:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            if (row_a === target) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic row_cols_a(input string name, input logic [7:0] target,
                              input logic [7:0] er, input logic [7:0] eg);
        bit found;
        wait_row_a(target, found);
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL %s row wait: got %h want %h", name, row_a, target);
        end else if (r_col_a !== er || g_col_a !== eg) begin
            n_err++;
            $display("FAIL %s cols: got r=%h g=%h want r=%h g=%h", name, r_col_a, g_col_a, er, eg);
        end
    endtask

    task automatic counts_a(input string name, input logic [3:0] el,
                            input logic [3:0] er, input logic ed);
        n_cmp++;
        if (cnt_l_a !== el || cnt_r_a !== er || done_a !== ed) begin
            n_err++;
            $display("FAIL %s: got l=%0d r=%0d done=%b want l=%0d r=%0d done=%b",
                     name, cnt_l_a, cnt_r_a, done_a, el, er, ed);
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_row;
        sw1 = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (row_a !== 8'hFF || r_col_a !== 8'h00 || g_col_a !== 8'h00) begin
            n_err++;
            $display("FAIL reset outputs: got row=%h r=%h g=%h want FF 00 00", row_a, r_col_a, g_col_a);
        end
        counts_a("reset counts", 4'd10, 4'd10, 1'b0);
        n_cmp++;
        if (row_b !== 8'hFF || r_col_b !== 8'h00 || cnt_l_b !== 4'd10) begin
            n_err++;
            $display("FAIL reset b: got row=%h r=%h l=%0d want FF 00 10", row_b, r_col_b, cnt_l_b);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (row_a !== 8'hFE || r_col_a !== 8'hFF || g_col_a !== 8'h00) begin
            n_err++;
            $display("FAIL first row: got row=%h r=%h g=%h want FE FF 00", row_a, r_col_a, g_col_a);
        end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            exp_row = ~(8'h01 << k);
            n_cmp++;
            if (row_a !== exp_row) begin
                n_err++;
                $display("FAIL scan row %0d: got %h want %h", k, row_a, exp_row);
            end
        end
    endtask

    task automatic test_drain3();
        repeat (3) do_tick();
        settle();
        counts_a("drain3 counts", 4'd8, 4'd9, 1'b0);
        row_cols_a("drain3 row0", 8'hFE, 8'hC7, 8'h38);
        row_cols_a("drain3 row3", 8'hF7, 8'h18, 8'h00);
        row_cols_a("drain3 row7", 8'h7F, 8'h38, 8'hC7);
    endtask

    task automatic test_drain_all();
        repeat (16) do_tick();
        settle();
        counts_a("drain19 counts", 4'd0, 4'd1, 1'b0);
        do_tick();
        settle();
        counts_a("drain20 counts", 4'd0, 4'd0, 1'b1);
        row_cols_a("empty row0", 8'hFE, 8'h00, 8'hFF);
        row_cols_a("empty row3", 8'hF7, 8'h00, 8'h18);
        row_cols_a("empty row4", 8'hEF, 8'h18, 8'h00);
        row_cols_a("empty row7", 8'h7F, 8'hFF, 8'h00);
        do_tick();
        settle();
        counts_a("tick21 ignored", 4'd0, 4'd0, 1'b1);
        row_cols_a("tick21 row0", 8'hFE, 8'h00, 8'hFF);
    endtask

    task automatic test_fill_skip();
        sw1 = 1'b1;
        apply_reset();
        repeat (3) do_tick();
        settle();
        sw1 = 1'b0;
        do_tick();
        settle();
        counts_a("fill tick1", 4'd8, 4'd10, 1'b0);
        do_tick();
        settle();
        counts_a("fill tick2", 4'd9, 4'd10, 1'b0);
        do_tick();
        settle();
        counts_a("fill tick3 skip", 4'd10, 4'd10, 1'b1);
        do_tick();
        settle();
        counts_a("fill tick4 ignored", 4'd10, 4'd10, 1'b1);
        row_cols_a("full row0", 8'hFE, 8'hFF, 8'h00);
        sw1 = 1'b1;
    endtask

    task automatic test_stop();
        sw1 = 1'b1;
        apply_reset();
        do_tick();
        stop = 1'b1;
        repeat (5) do_tick();
        settle();
        counts_a("stop frozen", 4'd9, 4'd10, 1'b0);
        row_cols_a("stop row0", 8'hFE, 8'hEF, 8'h10);
        row_cols_a("stop scan row5", 8'hDF, 8'h00, 8'h3C);
        stop = 1'b0;
        do_tick();
        settle();
        counts_a("resume right", 4'd9, 4'd9, 1'b0);
        do_tick();
        settle();
        counts_a("resume left", 4'd8, 4'd9, 1'b0);
    endtask

    task automatic test_blank();
        logic [7:0] msk_tab [4];
        logic [7:0] er, eg, erow;
        int slot;
        bit found;
        msk_tab[0] = 8'hFF; msk_tab[1] = 8'h7E; msk_tab[2] = 8'h3C; msk_tab[3] = 8'h18;
        sw1 = 1'b1;
        apply_reset();
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            slot = (k / 4) % 8;
            if (k % 4 == 0) begin
                erow = 8'hFF; er = 8'h00; eg = 8'h00;
            end else begin
                erow = ~(8'h01 << slot);
                er = (slot < 4) ? msk_tab[slot] : 8'h00;
                eg = (slot < 4) ? 8'h00 : msk_tab[7 - slot];
            end
            n_cmp++;
            if (row_b !== erow || r_col_b !== er || g_col_b !== eg) begin
                n_err++;
                $display("FAIL blank cycle %0d: got row=%h r=%h g=%h want %h %h %h",
                         k, row_b, r_col_b, g_col_b, erow, er, eg);
            end
        end
        do_tick();
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (row_b === 8'hFD) found = 1'b1;
        end
        n_cmp++;
        if (!found || cnt_l_b !== 4'd9) begin
            n_err++;
            $display("FAIL pre-reset b: got row=%h l=%0d want FD 9", row_b, cnt_l_b);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (row_b !== 8'hFF || r_col_b !== 8'h00 || g_col_b !== 8'h00 ||
            cnt_l_b !== 4'd10 || cnt_r_b !== 4'd10 || done_b !== 1'b0) begin
            n_err++;
            $display("FAIL async reset b: got row=%h r=%h g=%h l=%0d r=%0d d=%b want FF 00 00 10 10 0",
                     row_b, r_col_b, g_col_b, cnt_l_b, cnt_r_b, done_b);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (row_b !== 8'hFF || r_col_b !== 8'h00) begin
            n_err++;
            $display("FAIL release slot start: got row=%h r=%h want FF 00", row_b, r_col_b);
        end
        @(negedge clk);
        n_cmp++;
        if (row_b !== 8'hFE || r_col_b !== 8'hFF || g_col_b !== 8'h00) begin
            n_err++;
            $display("FAIL release row0: got row=%h r=%h g=%h want FE FF 00", row_b, r_col_b, g_col_b);
        end
    endtask

    initial begin
        test_reset();
        test_drain3();
        test_drain_all();
        test_fill_skip();
        test_stop();
        test_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
